// File: rtl/spmm_pkg.sv
// Shared types for the sparse-matrix read path: triplet layout, drain FSM states
// and terminator decoding.
package spmm_pkg;

    localparam int TRI_ROW_W = 4;
    localparam int TRI_COL_W = 4;
    localparam int TRI_VAL_W = 8;

    typedef struct packed {
        logic [TRI_ROW_W-1:0] row;
        logic [TRI_COL_W-1:0] col;
        logic [TRI_VAL_W-1:0] val;
    } triplet_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DRAIN,
        ST_DONE
    } drain_state_t;

    // A row index of all ones marks the end of a matrix stream.
    function automatic logic is_term(triplet_t t);
        return &t.row;
    endfunction

endpackage

// File: rtl/triplet_buf.sv
// Two-entry output buffer for captured RAM words, presented as a valid/ready
// stream with an occupancy count for the issuer's credit check.
module triplet_buf #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] din,
    output logic         valid,
    input  logic         ready,
    output logic [W-1:0] head,
    output logic [1:0]   occ
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         pop;

    assign valid = (occ != 2'd0);
    assign pop   = valid && ready;
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: storage is reset here because the head entry drives the
            // stream outputs directly and must read as zero after reset.
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_drain_reader.sv
// Read-side client of the pointer FIFO controller: pops words while there is
// buffer room, decodes them as {row,col,val} triplets and streams them out.
module fifo_drain_reader
    import spmm_pkg::*;
#(
    parameter int ROW_W  = 4,
    parameter int COL_W  = 4,
    parameter int VAL_W  = 8,
    parameter int RD_LAT = 2,
    parameter int CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     fifo_empty,
    output logic                     fifo_en,
    output logic                     fifo_rw,
    input  logic [ROW_W+COL_W+VAL_W-1:0] ram_rdata,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ROW_W-1:0]         out_row,
    output logic [COL_W-1:0]         out_col,
    output logic [VAL_W-1:0]         out_val,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done,
    output logic [CNT_W-1:0]         elem_count
);

    localparam int W     = ROW_W + COL_W + VAL_W;
    localparam int LAT_W = $clog2(RD_LAT + 1);

    drain_state_t     state;
    logic [LAT_W-1:0] lat_cnt;
    logic [1:0]       occ;
    logic [W-1:0]     head;
    logic             capture;
    logic             transfer;
    logic             rdata_term;

    assign fifo_rw    = 1'b0;
    assign capture    = (state == ST_WAIT) && (lat_cnt == LAT_W'(RD_LAT - 1));
    assign transfer   = out_valid && out_ready;
    assign rdata_term = &ram_rdata[W-1 -: ROW_W];

    triplet_buf #(.W(W)) u_buf (
        .clk   (clk),
        .reset (reset),
        .push  (capture),
        .din   (ram_rdata),
        .valid (out_valid),
        .ready (out_ready),
        .head  (head),
        .occ   (occ)
    );

    assign out_row  = head[W-1 -: ROW_W];
    assign out_col  = head[COL_W+VAL_W-1 -: COL_W];
    assign out_val  = head[VAL_W-1:0];
    assign out_last = out_valid && (&out_row);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            lat_cnt <= '0;
            fifo_en <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            fifo_en <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state <= ST_ISSUE;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    // Nothing is in flight while in ISSUE, so occupancy alone is the credit.
                    if (!fifo_empty && occ < 2'd2) begin
                        fifo_en <= 1'b1;
                        lat_cnt <= '0;
                        state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (capture) begin
                        state <= rdata_term ? ST_DRAIN : ST_ISSUE;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (occ == 2'd0) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            elem_count <= '0;
        end else if ((state == ST_IDLE || state == ST_DONE) && start) begin
            elem_count <= '0;
        end else if (transfer && !out_last && elem_count != '1) begin
            elem_count <= elem_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_drain_reader.sv
// Directed bench for fifo_drain_reader: a behavioural FIFO controller model feeds
// words, and each scenario task checks stream contents, pop timing and status.
module tb_fifo_drain_reader;
    import spmm_pkg::*;

    logic        clk = 1'b0;
    logic        reset, start, fifo_empty, out_ready;
    logic [15:0] ram_rdata;
    logic        fifo_en, fifo_rw, out_valid, out_last, busy, done;
    logic [3:0]  out_row, out_col;
    logic [7:0]  out_val;
    logic [7:0]  elem_count;
    logic        fifo_en_b, fifo_rw_b, out_valid_b, out_last_b, busy_b, done_b;
    logic [3:0]  out_row_b, out_col_b;
    logic [7:0]  out_val_b;
    logic [1:0]  elem_count_b;

    fifo_drain_reader dut (
        .clk(clk), .reset(reset), .start(start), .fifo_empty(fifo_empty),
        .fifo_en(fifo_en), .fifo_rw(fifo_rw), .ram_rdata(ram_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
        .out_col(out_col), .out_val(out_val), .out_last(out_last),
        .busy(busy), .done(done), .elem_count(elem_count)
    );

    // Same stimulus, narrow counter, to exercise saturation.
    fifo_drain_reader #(.CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .start(start), .fifo_empty(fifo_empty),
        .fifo_en(fifo_en_b), .fifo_rw(fifo_rw_b), .ram_rdata(ram_rdata),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_row(out_row_b),
        .out_col(out_col_b), .out_val(out_val_b), .out_last(out_last_b),
        .busy(busy_b), .done(done_b), .elem_count(elem_count_b)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Controller model: word store written by the stimulus, read on each pop.
    logic [15:0] mem_w [256];
    int          wp = 0;
    int          rp = 0;
    int          cyc = 0;

    assign fifo_empty = (wp == rp);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) begin
            rp <= wp;
        end else if (fifo_en && wp != rp) begin
            ram_rdata <= mem_w[rp];
            rp        <= rp + 1;
        end
    end

    logic [16:0] got[$];
    int          en_cyc[$];
    int          en_wide = 0;
    int          rw_bad = 0;
    logic        en_prev = 1'b0;

    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid && out_ready) got.push_back({out_last, out_row, out_col, out_val});
            if (fifo_en) en_cyc.push_back(cyc);
            if (fifo_en && en_prev) en_wide <= en_wide + 1;
            if (fifo_rw !== 1'b0 || fifo_rw_b !== 1'b0) rw_bad <= rw_bad + 1;
        end
        en_prev <= fifo_en;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [15:0] w);
        mem_w[wp] = w;
        wp = wp + 1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
    endtask

    task automatic wait_done(input string name);
        int k = 0;
        while (!done && k < 200) begin
            tick(1);
            k++;
        end
        n_cmp++;
        if (done !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_done: done=%b required 1 after %0d cycles", name, done, k);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({fifo_en, fifo_rw, out_valid, out_last} !== 4'b0) begin
            n_bad++;
            $display("FAIL reset_strobes: en/rw/valid/last=%b required 0000",
                     {fifo_en, fifo_rw, out_valid, out_last});
        end
        n_cmp++;
        if ({out_row, out_col, out_val} !== 16'h0) begin
            n_bad++;
            $display("FAIL reset_data: %h required 0000", {out_row, out_col, out_val});
        end
        n_cmp++;
        if ({busy, done} !== 2'b00 || elem_count !== 8'd0) begin
            n_bad++;
            $display("FAIL reset_status: busy=%b done=%b count=%0d required 0 0 0",
                     busy, done, elem_count);
        end
    endtask

    task automatic test_basic();
        logic [16:0] exp_q[3] = '{17'h01205, 17'h0340A, 17'h1F000};
        int base = got.size();
        out_ready = 1'b1;
        load(16'h1205); load(16'h340A); load(16'hF000);
        pulse_start();
        wait_done("basic");
        n_cmp++;
        if (got.size() - base !== 3) begin
            n_bad++;
            $display("FAIL basic_count: %0d transfers required 3", got.size() - base);
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (got[base+i] !== exp_q[i]) begin
                    n_bad++;
                    $display("FAIL basic_item%0d: %h required %h", i, got[base+i], exp_q[i]);
                end
            end
        end
        n_cmp++;
        if (elem_count !== 8'd2 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_status: count=%0d busy=%b required 2 0", elem_count, busy);
        end
    endtask

    task automatic test_empty_start();
        int eb = en_cyc.size();
        int wide0 = en_wide;
        int base = got.size();
        pulse_start();
        tick(10);
        n_cmp++;
        if (en_cyc.size() - eb !== 0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL empty_hold: pops=%0d busy=%b required 0 1", en_cyc.size() - eb, busy);
        end
        load(16'h2103);
        tick(10);
        n_cmp++;
        if (en_cyc.size() - eb !== 1 || en_wide !== wide0) begin
            n_bad++;
            $display("FAIL empty_one_pop: pops=%0d wide=%0d required 1 0",
                     en_cyc.size() - eb, en_wide - wide0);
        end
        load(16'hF122);
        wait_done("empty");
        n_cmp++;
        if (got.size() - base !== 2 || got[base] !== 17'h02103) begin
            n_bad++;
            $display("FAIL empty_data: n=%0d first=%h required 2 02103", got.size() - base, got[base]);
        end
    endtask

    task automatic test_backpressure();
        logic [16:0] exp_q[5] = '{17'h01111, 17'h02222, 17'h03333, 17'h04444, 17'h1F0FF};
        int eb = en_cyc.size();
        int base = got.size();
        out_ready = 1'b0;
        load(16'h1111); load(16'h2222); load(16'h3333); load(16'h4444);
        pulse_start();
        tick(20);
        n_cmp++;
        if (en_cyc.size() - eb !== 2) begin
            n_bad++;
            $display("FAIL bp_pops: %0d pops required 2", en_cyc.size() - eb);
        end
        n_cmp++;
        if (out_valid !== 1'b1 || {out_row, out_col, out_val} !== 16'h1111) begin
            n_bad++;
            $display("FAIL bp_head: valid=%b head=%h required 1 1111", out_valid, {out_row, out_col, out_val});
        end
        tick(8);
        n_cmp++;
        if (out_valid !== 1'b1 || {out_row, out_col, out_val} !== 16'h1111 || got.size() != base) begin
            n_bad++;
            $display("FAIL bp_stable: valid=%b head=%h required 1 1111", out_valid, {out_row, out_col, out_val});
        end
        out_ready = 1'b1;
        load(16'hF0FF);
        wait_done("bp");
        n_cmp++;
        if (got.size() - base !== 5) begin
            n_bad++;
            $display("FAIL bp_count: %0d transfers required 5", got.size() - base);
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_cmp++;
                if (got[base+i] !== exp_q[i]) begin
                    n_bad++;
                    $display("FAIL bp_item%0d: %h required %h", i, got[base+i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int eb = en_cyc.size();
        int wide0 = en_wide;
        out_ready = 1'b1;
        load(16'h5501); load(16'h5602); load(16'h5703); load(16'h5804); load(16'hFF05);
        pulse_start();
        wait_done("b2b");
        n_cmp++;
        if (en_cyc.size() - eb !== 5) begin
            n_bad++;
            $display("FAIL b2b_pops: %0d pops required 5", en_cyc.size() - eb);
        end else begin
            for (int i = 1; i < 5; i++) begin
                n_cmp++;
                if (en_cyc[eb+i] - en_cyc[eb+i-1] !== 3) begin
                    n_bad++;
                    $display("FAIL b2b_gap%0d: %0d cycles required 3", i, en_cyc[eb+i] - en_cyc[eb+i-1]);
                end
            end
        end
        n_cmp++;
        if (rw_bad !== 0 || en_wide !== wide0 || elem_count !== 8'd4) begin
            n_bad++;
            $display("FAIL b2b_misc: rw_bad=%0d wide=%0d count=%0d required 0 0 4",
                     rw_bad, en_wide - wide0, elem_count);
        end
    endtask

    task automatic test_saturate();
        out_ready = 1'b1;
        for (int i = 1; i <= 5; i++) load(16'h0101 * 16'(i));
        load(16'hF000);
        pulse_start();
        wait_done("sat");
        n_cmp++;
        if (elem_count !== 8'd5 || elem_count_b !== 2'd3 || done_b !== 1'b1) begin
            n_bad++;
            $display("FAIL sat_count: wide=%0d narrow=%0d done_b=%b required 5 3 1",
                     elem_count, elem_count_b, done_b);
        end
        pulse_start();
        n_cmp++;
        if (elem_count_b !== 2'd0 || elem_count !== 8'd0 || busy !== 1'b1 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL sat_restart: narrow=%0d wide=%0d busy=%b done=%b required 0 0 1 0",
                     elem_count_b, elem_count, busy, done);
        end
    endtask

    task automatic test_reset_mid_wait();
        int eb, base, k;
        do_reset();
        eb = en_cyc.size();
        base = got.size();
        out_ready = 1'b1;
        load(16'h1A01); load(16'h2B02);
        pulse_start();
        k = 0;
        while (en_cyc.size() - eb < 2 && k < 40) begin
            tick(1);
            k++;
        end
        n_cmp++;
        if (en_cyc.size() - eb !== 2 || elem_count !== 8'd1) begin
            n_bad++;
            $display("FAIL rst_setup: pops=%0d count=%0d required 2 1", en_cyc.size() - eb, elem_count);
        end
        reset = 1'b1;
        tick(1);
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || elem_count !== 8'd0) begin
            n_bad++;
            $display("FAIL rst_state: valid=%b busy=%b done=%b count=%0d required 0 0 0 0",
                     out_valid, busy, done, elem_count);
        end
        reset = 1'b0;
        tick(6);
        n_cmp++;
        if (out_valid !== 1'b0 || got.size() - base !== 1 || en_cyc.size() - eb !== 2) begin
            n_bad++;
            $display("FAIL rst_no_late: valid=%b transfers=%0d pops=%0d required 0 1 2",
                     out_valid, got.size() - base, en_cyc.size() - eb);
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        out_ready = 1'b1;
        ram_rdata = 16'h0;
        test_reset();
        test_basic();
        test_empty_start();
        test_backpressure();
        test_back_to_back();
        test_saturate();
        test_reset_mid_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
